// File: rtl/dac_seq_pkg.sv
// Shared types for the DAC write sequencer: sample width, the queued entry
// layout and the handshake FSM states.
package dac_seq_pkg;

   localparam int DAC_DATA_W = 10;

   typedef struct packed {
      logic                  channel;
      logic [DAC_DATA_W-1:0] data;
   } dac_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE
   } dac_state_t;

endpackage

// File: rtl/dac_write_sequencer_sample_fifo.sv
// sample_fifo: single-clock synchronous FIFO with registered full/empty flags.
// A push into a full FIFO is only taken when a pop happens in the same clock.
module sample_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 11
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wrData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdData_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             full_q;
   logic             empty_q;
   logic             pushOk;
   logic             popOk;

   // Decide which requests are honoured and what the occupancy becomes.
   always_comb begin
      popOk   = pop_i && !empty_q;
      pushOk  = push_i && (!full_q || popOk);
      count_d = count_q;
      unique case ({pushOk, popOk})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers, occupancy and the flags derived from the next occupancy.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (pushOk) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (popOk)  rdPtr_q <= rdPtr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Storage array; contents need no reset since the flags gate every read.
   always_ff @(posedge clk_i) begin
      if (pushOk) mem_q[wrPtr_q] <= wrData_i;
   end

   assign rdData_o = mem_q[rdPtr_q];
   assign full_o   = full_q;
   assign empty_o  = empty_q;

endmodule

// File: rtl/dac_write_sequencer.sv
// dac_write_sequencer: queues channel-tagged samples and issues them one at a
// time to the Mercury2 DAC, waiting on Busy and flagging a DAC that never
// acknowledges. Optional macro DAC_SEQ_DROP_CNT_EN adds a saturating
// drop_count output for writes rejected by a full queue.
module dac_write_sequencer
   import dac_seq_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                  clk_50MHZ,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  wr_channel,
   input  logic [DAC_DATA_W-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   output logic                  trigger,
   output logic                  channel,
   output logic [DAC_DATA_W-1:0] Din,
   input  logic                  Busy,
   output logic                  timeout_err
`ifdef DAC_SEQ_DROP_CNT_EN
   ,
   output logic [7:0]            drop_count
`endif
);

   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   dac_state_t            state_q;
   logic                  trigger_q;
   logic                  channel_q;
   logic [DAC_DATA_W-1:0] din_q;
   logic [CNT_W-1:0]      tmoCnt_q;
   logic                  timeoutErr_q;
   logic                  pop;
   dac_entry_t            wrEntry;
   dac_entry_t            headEntry;
   logic [$bits(dac_entry_t)-1:0] headBits;

   assign wrEntry   = '{channel: wr_channel, data: wr_data};
   assign headEntry = dac_entry_t'(headBits);
   assign pop       = (state_q == IDLE) && !empty && !Busy;

   sample_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(dac_entry_t))
   ) u_fifo (
      .clk_i    (clk_50MHZ),
      .reset_i  (reset),
      .push_i   (wr_en),
      .wrData_i (wrEntry),
      .pop_i    (pop),
      .rdData_o (headBits),
      .full_o   (full),
      .empty_o  (empty)
   );

   // Handshake FSM: pop a sample, strobe trigger once, wait for Busy to rise
   // (or give up after the timeout), then wait for the conversion to finish.
   always_ff @(posedge clk_50MHZ) begin
      if (reset) begin
         state_q      <= IDLE;
         trigger_q    <= 1'b0;
         channel_q    <= 1'b0;
         din_q        <= '0;
         tmoCnt_q     <= '0;
         timeoutErr_q <= 1'b0;
      end else begin
         trigger_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  channel_q <= headEntry.channel;
                  din_q     <= headEntry.data;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               trigger_q <= 1'b1;
               tmoCnt_q  <= CNT_W'(BUSY_TIMEOUT);
               state_q   <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (Busy) begin
                  state_q <= WAIT_DONE;
               end else if (tmoCnt_q == '0) begin
                  timeoutErr_q <= 1'b1;
                  state_q      <= IDLE;
               end else begin
                  tmoCnt_q <= tmoCnt_q - CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!Busy) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign trigger     = trigger_q;
   assign channel     = channel_q;
   assign Din         = din_q;
   assign timeout_err = timeoutErr_q;

`ifdef DAC_SEQ_DROP_CNT_EN
   logic [7:0] dropCnt_q;

   // Count writes lost to a full queue (a same-clock pop makes room instead).
   always_ff @(posedge clk_50MHZ) begin
      if (reset) begin
         dropCnt_q <= '0;
      end else if (wr_en && full && !pop && (dropCnt_q != 8'hFF)) begin
         dropCnt_q <= dropCnt_q + 8'd1;
      end
   end

   assign drop_count = dropCnt_q;
`endif

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Directed testbench for dac_write_sequencer with a behavioural DAC model that
// raises Busy the clock after each trigger and holds it for 72 clocks.
module tb_dac_write_sequencer;

   localparam int DAC_BUSY_CLKS = 72;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic       wr_channel;
   logic [9:0] wr_data;
   logic       full;
   logic       empty;
   logic       trigger;
   logic       channel;
   logic [9:0] Din;
   logic       Busy;
   logic       timeout_err;
`ifdef DAC_SEQ_DROP_CNT_EN
   logic [7:0] drop_count;
`endif

   logic       busyHold;
   logic       busyTieLow;
   int         busyCnt;
   int         testCount;
   int         failCount;
   int         cycle;
   int         lastFall;
   int         minGap;
   int         trigWhileBusy;
   logic       prevBusy;
   logic [10:0] trigLog[$];

   dac_write_sequencer #(
      .DEPTH        (8),
      .BUSY_TIMEOUT (4)
   ) dut (
      .clk_50MHZ   (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_channel  (wr_channel),
      .wr_data     (wr_data),
      .full        (full),
      .empty       (empty),
      .trigger     (trigger),
      .channel     (channel),
      .Din         (Din),
      .Busy        (Busy),
      .timeout_err (timeout_err)
`ifdef DAC_SEQ_DROP_CNT_EN
      ,
      .drop_count  (drop_count)
`endif
   );

   // 50 MHz clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // DAC model: Busy rises the clock after trigger and stays high for a
   // fixed conversion time; the model itself ignores the sequencer reset.
   initial busyCnt = 0;
   always @(posedge clk) begin
      if (trigger && !busyTieLow && busyCnt == 0) busyCnt <= DAC_BUSY_CLKS;
      else if (busyCnt > 0) busyCnt <= busyCnt - 1;
   end
   assign Busy = busyTieLow ? 1'b0 : ((busyCnt != 0) || busyHold);

   // Monitor: log every trigger with its channel/data and track spacing
   // from the most recent Busy fall.
   initial begin
      cycle = 0; lastFall = -1; minGap = 1000; trigWhileBusy = 0; prevBusy = 1'b0;
   end
   always @(negedge clk) begin
      cycle++;
      if (prevBusy && !Busy) lastFall = cycle;
      if (trigger === 1'b1) begin
         trigLog.push_back({channel, Din});
         if (lastFall >= 0 && (cycle - lastFall) < minGap) minGap = cycle - lastFall;
         if (Busy) trigWhileBusy++;
      end
      prevBusy = Busy;
   end

   // Watchdog so the run always terminates.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic ch, input logic [9:0] data);
      wr_en      = en;
      wr_channel = ch;
      wr_data    = data;
      @(negedge clk);
   endtask

   task automatic waitTriggers(input int n, input int budget, input string tag);
      int k = 0;
      while (trigLog.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkOutput(tag, 32'(trigLog.size() >= n), 32'd1);
   endtask

   task automatic waitBusyIdle(input int budget, input string tag);
      int k = 0;
      repeat (2) @(negedge clk);
      while (Busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkOutput(tag, 32'(Busy), 32'd0);
      repeat (4) @(negedge clk);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_empty"},   32'(empty),       32'd1);
      checkOutput({tag, "_full"},    32'(full),        32'd0);
      checkOutput({tag, "_trigger"}, 32'(trigger),     32'd0);
      checkOutput({tag, "_channel"}, 32'(channel),     32'd0);
      checkOutput({tag, "_din"},     32'(Din),         32'd0);
      checkOutput({tag, "_tmo"},     32'(timeout_err), 32'd0);
   endtask

   initial begin
      int unstable;
      int k;
      logic seenBusy;
      testCount = 0; failCount = 0;
      reset = 1'b1; wr_en = 1'b0; wr_channel = 1'b0; wr_data = '0;
      busyHold = 1'b0; busyTieLow = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkResetValues("rst");

      // Single sample: trigger two clocks after the write, data held through Busy
      trigLog.delete();
      applyStimulus(1'b1, 1'b0, 10'h155);
      wr_en = 1'b0;
      checkOutput("t1_trig_k", 32'(trigger), 32'd0);
      @(negedge clk);
      checkOutput("t1_trig_k1", 32'(trigger), 32'd0);
      @(negedge clk);
      checkOutput("t1_trig_k2", 32'(trigger), 32'd1);
      checkOutput("t1_channel", 32'(channel), 32'd0);
      checkOutput("t1_din",     32'(Din),     32'h155);
      checkOutput("t1_empty",   32'(empty),   32'd1);
      @(negedge clk);
      checkOutput("t1_trig_once", 32'(trigger), 32'd0);
      checkOutput("t1_busy_up",   32'(Busy),    32'd1);
      unstable = 0; seenBusy = 1'b0; k = 0;
      while (!(seenBusy && !Busy) && k < 200) begin
         if (Busy) begin
            seenBusy = 1'b1;
            if (Din !== 10'h155 || channel !== 1'b0) unstable++;
         end
         @(negedge clk);
         k++;
      end
      checkOutput("t1_busy_fell",  32'(Busy),     32'd0);
      checkOutput("t1_din_stable", 32'(unstable), 32'd0);
      repeat (4) @(negedge clk);
      checkOutput("t1_trig_count", 32'(trigLog.size()), 32'd1);

      // Three back-to-back samples, issued in order with spacing after Busy falls
      trigLog.delete();
      minGap = 1000;
      applyStimulus(1'b1, 1'b1, 10'h3FF);
      applyStimulus(1'b1, 1'b0, 10'h000);
      applyStimulus(1'b1, 1'b1, 10'h200);
      wr_en = 1'b0;
      waitTriggers(3, 400, "t2_three_triggers");
      waitBusyIdle(200, "t2_idle");
      checkOutput("t2_count", 32'(trigLog.size()), 32'd3);
      checkOutput("t2_first",  32'(trigLog[0]), 32'({1'b1, 10'h3FF}));
      checkOutput("t2_second", 32'(trigLog[1]), 32'({1'b0, 10'h000}));
      checkOutput("t2_third",  32'(trigLog[2]), 32'({1'b1, 10'h200}));
      checkOutput("t2_gap_ge2", 32'(minGap >= 2), 32'd1);
      checkOutput("t2_empty", 32'(empty), 32'd1);

      // Ten writes while the DAC is busy: fill, drop two, then a write that
      // coincides with the first pop must be accepted and come out last
      trigLog.delete();
      minGap = 1000;
      busyHold = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, i[0], 10'(32'h040 + i));
         if (i == 6) checkOutput("t3_not_full_7", 32'(full), 32'd0);
         if (i == 7) checkOutput("t3_full_8",     32'(full), 32'd1);
      end
      checkOutput("t3_full_after_10", 32'(full), 32'd1);
`ifdef DAC_SEQ_DROP_CNT_EN
      checkOutput("t3_drop_count", 32'(drop_count), 32'd2);
`endif
      busyHold = 1'b0;
      applyStimulus(1'b1, 1'b1, 10'h2AA);
      checkOutput("t3_full_on_pop_write", 32'(full),  32'd1);
      checkOutput("t3_not_empty",         32'(empty), 32'd0);
`ifdef DAC_SEQ_DROP_CNT_EN
      checkOutput("t3_drop_unchanged", 32'(drop_count), 32'd2);
`endif
      applyStimulus(1'b0, 1'b0, 10'h000);
      checkOutput("t3_still_full", 32'(full), 32'd1);
      waitTriggers(9, 1000, "t3_nine_triggers");
      waitBusyIdle(200, "t3_idle");
      checkOutput("t3_count", 32'(trigLog.size()), 32'd9);
      for (int i = 0; i < 8; i++) begin
         logic [10:0] expEntry;
         expEntry = {i[0], 10'(32'h040 + i)};
         checkOutput($sformatf("t3_entry%0d", i), 32'(trigLog[i]), 32'(expEntry));
      end
      checkOutput("t3_last_is_popwrite", 32'(trigLog[8]), 32'({1'b1, 10'h2AA}));
      checkOutput("t3_gap_ge2", 32'(minGap >= 2), 32'd1);
      checkOutput("t3_empty", 32'(empty), 32'd1);

      // DAC never acknowledges: timeout_err after BUSY_TIMEOUT+1 clocks
      trigLog.delete();
      busyTieLow = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 10'h0AB);
      wr_en = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("t4_trigger", 32'(trigger), 32'd1);
      repeat (4) @(negedge clk);
      checkOutput("t4_tmo_early", 32'(timeout_err), 32'd0);
      @(negedge clk);
      checkOutput("t4_tmo_set", 32'(timeout_err), 32'd1);
      repeat (5) @(negedge clk);
      checkOutput("t4_one_trigger", 32'(trigLog.size()), 32'd1);
      busyTieLow = 1'b0;
      applyStimulus(1'b1, 1'b1, 10'h1CD);
      wr_en = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("t4_next_trigger", 32'(trigger), 32'd1);
      checkOutput("t4_next_data",    32'({channel, Din}), 32'({1'b1, 10'h1CD}));
      waitBusyIdle(200, "t4_idle");
      checkOutput("t4_tmo_sticky", 32'(timeout_err), 32'd1);

      // Reset mid-conversion with four entries queued
      trigLog.delete();
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, i[0], 10'(32'h300 + i));
      wr_en = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("t5_busy_pre",  32'(Busy),  32'd1);
      checkOutput("t5_queued",    32'(empty), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkResetValues("t5_rst");
      trigLog.delete();
      waitBusyIdle(200, "t5_busy_fell");
      repeat (5) @(negedge clk);
      checkOutput("t5_no_trigger", 32'(trigLog.size()), 32'd0);
      checkOutput("t5_empty", 32'(empty), 32'd1);
      applyStimulus(1'b1, 1'b0, 10'h0F0);
      wr_en = 1'b0;
      waitTriggers(1, 10, "t5_new_trigger");
      checkOutput("t5_new_data", 32'(trigLog[0]), 32'({1'b0, 10'h0F0}));
      waitBusyIdle(200, "t5_idle");

      checkOutput("no_trigger_while_busy", 32'(trigWhileBusy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
